// File: rtl/shared_sbox_layer_ctrl.sv
// shared_sbox_layer_ctrl: feeds a masked state one nibble per cycle through an external S-box pipeline and collects the result shares
module shared_sbox_layer_ctrl #(
  parameter int LATENCY = 1,
  parameter int NIB = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [4*NIB-1:0] state0_i,
  input  logic [4*NIB-1:0] state1_i,
  input  logic [15:0]      seed_i,
  output logic [3:0]       sb_in0_o,
  output logic [3:0]       sb_in1_o,
  output logic [1:0]       sb_guards_o,
  input  logic [3:0]       sb_out0_i,
  input  logic [3:0]       sb_out1_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [4*NIB-1:0] state0_o,
  output logic [4*NIB-1:0] state1_o
);
  localparam int FW = $clog2(NIB + 1);
  localparam int LW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [FW-1:0] r_feed_cnt;
  logic [LW-1:0] r_lat_cnt;
  logic [LATENCY-1:0] r_vld;
  logic [15:0] r_lfsr;
  logic [4*NIB-1:0] r_in0, r_in1, r_res0, r_res1, w_res0, w_res1;
  logic w_feed, w_cap, w_accept, w_enter_done;
  always_comb begin
    w_feed = r_state == FEED;
    w_cap = r_vld[LATENCY-1];
    w_accept = r_state == IDLE && start_i;
    w_next = r_state == IDLE ? (start_i ? FEED : IDLE) :
             r_state == FEED ? (r_feed_cnt == FW'(NIB - 1) ? DRAIN : FEED) :
             r_state == DRAIN ? (r_lat_cnt == LW'(LATENCY - 1) ? DONE : DRAIN) : IDLE;
    w_enter_done = r_state == DRAIN && w_next == DONE;
    w_res0 = w_cap ? {sb_out0_i, r_res0[4*NIB-1:4]} : r_res0;
    w_res1 = w_cap ? {sb_out1_i, r_res1[4*NIB-1:4]} : r_res1;
    busy_o = r_state == FEED || r_state == DRAIN;
    done_o = r_state == DONE;
    sb_in0_o = w_feed ? r_in0[3:0] : 4'h0;
    sb_in1_o = w_feed ? r_in1[3:0] : 4'h0;
    sb_guards_o = w_feed ? r_lfsr[1:0] : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_feed_cnt <= '0;
      r_lat_cnt <= '0;
      r_vld <= '0;
      r_lfsr <= 16'hACE1;
      r_in0 <= '0;
      r_in1 <= '0;
      r_res0 <= '0;
      r_res1 <= '0;
      state0_o <= '0;
      state1_o <= '0;
    end else begin
      r_state <= w_next;
      r_feed_cnt <= w_feed ? r_feed_cnt + 1'b1 : '0;
      r_lat_cnt <= r_state == DRAIN ? r_lat_cnt + 1'b1 : '0;
      r_vld <= LATENCY'({r_vld, w_feed});
      r_res0 <= w_res0;
      r_res1 <= w_res1;
      if (w_accept) begin
        r_in0 <= state0_i;
        r_in1 <= state1_i;
        r_lfsr <= seed_i == 16'h0 ? 16'hACE1 : seed_i;
      end else if (w_feed) begin
        r_in0 <= r_in0 >> 4;
        r_in1 <= r_in1 >> 4;
        r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
      end
      if (w_enter_done) begin
        state0_o <= w_res0;
        state1_o <= w_res1;
      end
    end
  end
endmodule

// File: tb/tb_shared_sbox_layer_ctrl.sv
// tb_shared_sbox_layer_ctrl: directed checks of the layer controller at LATENCY 1 and 4 with stub S-box pipelines
module tb_shared_sbox_layer_ctrl;
  logic clk = 0, rst = 1, start_i = 0;
  logic [63:0] state0_i = '0, state1_i = '0;
  logic [15:0] seed_i = '0;
  logic [3:0] a_in0, a_in1, a_out0, a_out1, b_in0, b_in1, b_out0, b_out1;
  logic [1:0] a_g, b_g;
  logic a_busy, a_done, b_busy, b_done;
  logic [63:0] a_s0, a_s1, b_s0, b_s1;
  logic [3:0] p1_0, p1_1;
  logic [3:0] p4_0 [4];
  logic [3:0] p4_1 [4];
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  shared_sbox_layer_ctrl #(.LATENCY(1), .NIB(16)) u_a (
    .clk(clk), .rst(rst), .start_i(start_i), .state0_i(state0_i), .state1_i(state1_i), .seed_i(seed_i),
    .sb_in0_o(a_in0), .sb_in1_o(a_in1), .sb_guards_o(a_g), .sb_out0_i(a_out0), .sb_out1_i(a_out1),
    .busy_o(a_busy), .done_o(a_done), .state0_o(a_s0), .state1_o(a_s1));
  shared_sbox_layer_ctrl #(.LATENCY(4), .NIB(16)) u_b (
    .clk(clk), .rst(rst), .start_i(start_i), .state0_i(state0_i), .state1_i(state1_i), .seed_i(seed_i),
    .sb_in0_o(b_in0), .sb_in1_o(b_in1), .sb_guards_o(b_g), .sb_out0_i(b_out0), .sb_out1_i(b_out1),
    .busy_o(b_busy), .done_o(b_done), .state0_o(b_s0), .state1_o(b_s1));
  always @(posedge clk) begin
    p1_0 <= a_in0 ^ 4'hF;
    p1_1 <= a_in1;
    p4_0[0] <= b_in0 ^ 4'hF;
    p4_1[0] <= b_in1;
    for (int i = 1; i < 4; i++) begin
      p4_0[i] <= p4_0[i-1];
      p4_1[i] <= p4_1[i-1];
    end
  end
  assign a_out0 = p1_0;
  assign a_out1 = p1_1;
  assign b_out0 = p4_0[3];
  assign b_out1 = p4_1[3];

  task automatic layer(input logic [63:0] s0, input logic [63:0] s1, input logic [15:0] seed,
                       input int pulse_at, input int rst_at);
    logic [15:0] lf;
    logic [63:0] e0, e1;
    bit ab;
    lf = (seed == 16'h0) ? 16'hACE1 : seed;
    ab = 0;
    state0_i = s0; state1_i = s1; seed_i = seed; start_i = 1;
    @(posedge clk); #1;
    start_i = 0; state0_i = ~s1; state1_i = ~s0; seed_i = 16'h1234;
    for (int j = 1; j <= 26; j++) begin
      checks += 4;
      if (a_busy !== (!ab && j <= 17)) $display("FAIL busy_a j=%0d got %b exp %b", j, a_busy, !ab && j <= 17); else passed++;
      if (a_done !== (!ab && j == 18)) $display("FAIL done_a j=%0d got %b exp %b", j, a_done, !ab && j == 18); else passed++;
      if (b_busy !== (!ab && j <= 20)) $display("FAIL busy_b j=%0d got %b exp %b", j, b_busy, !ab && j <= 20); else passed++;
      if (b_done !== (!ab && j == 21)) $display("FAIL done_b j=%0d got %b exp %b", j, b_done, !ab && j == 21); else passed++;
      if (!ab && j <= 16) begin
        checks += 4;
        if (a_g !== lf[1:0]) $display("FAIL guards_a j=%0d got %b exp %b", j, a_g, lf[1:0]); else passed++;
        if (b_g !== lf[1:0]) $display("FAIL guards_b j=%0d got %b exp %b", j, b_g, lf[1:0]); else passed++;
        if (a_in0 !== s0[4*(j-1) +: 4]) $display("FAIL sb_in0_a j=%0d got %h exp %h", j, a_in0, s0[4*(j-1) +: 4]); else passed++;
        if (b_in1 !== s1[4*(j-1) +: 4]) $display("FAIL sb_in1_b j=%0d got %h exp %h", j, b_in1, s1[4*(j-1) +: 4]); else passed++;
        lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
      end else begin
        checks++;
        if ({a_in0, a_in1, a_g, b_in0, b_in1, b_g} !== 20'h0)
          $display("FAIL sb_idle j=%0d got %h exp 0", j, {a_in0, a_in1, a_g, b_in0, b_in1, b_g});
        else passed++;
      end
      if (ab && j == rst_at + 1) begin
        checks++;
        if ({a_s0, a_s1, b_s0, b_s1} !== 256'h0) $display("FAIL abort_outs got %h exp 0", {a_s0, a_s1, b_s0, b_s1}); else passed++;
      end
      start_i = (j == pulse_at);
      rst = (j == rst_at);
      if (j == rst_at) ab = 1;
      @(posedge clk); #1;
    end
    rst = 0;
    e0 = ab ? 64'h0 : s0 ^ {16{4'hF}};
    e1 = ab ? 64'h0 : s1;
    checks += 4;
    if (a_s0 !== e0) $display("FAIL res0_a got %h exp %h", a_s0, e0); else passed++;
    if (a_s1 !== e1) $display("FAIL res1_a got %h exp %h", a_s1, e1); else passed++;
    if (b_s0 !== e0) $display("FAIL res0_b got %h exp %h", b_s0, e0); else passed++;
    if (b_s1 !== e1) $display("FAIL res1_b got %h exp %h", b_s1, e1); else passed++;
  endtask

  task automatic test_reset;
    rst = 1; start_i = 1; state0_i = 64'h0123456789ABCDEF; state1_i = 64'h1; seed_i = 16'h7;
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    if ({a_busy, a_done, b_busy, b_done} !== 4'h0) $display("FAIL reset_ctl got %b exp 0", {a_busy, a_done, b_busy, b_done}); else passed++;
    if ({a_s0, a_s1, b_s0, b_s1} !== 256'h0) $display("FAIL reset_outs got %h exp 0", {a_s0, a_s1, b_s0, b_s1}); else passed++;
    if ({a_in0, a_in1, a_g, b_in0, b_in1, b_g} !== 20'h0) $display("FAIL reset_sb got %h exp 0", {a_in0, a_in1, a_g, b_in0, b_in1, b_g}); else passed++;
    rst = 0; start_i = 0;
    @(posedge clk); #1;
    checks++;
    if ({a_busy, b_busy} !== 2'b00) $display("FAIL post_reset_busy got %b exp 00", {a_busy, b_busy}); else passed++;
  endtask

  task automatic test_basic;
    layer(64'h0123456789ABCDEF, 64'h0, 16'h0, 0, 0);
  endtask

  task automatic test_vector_lat4;
    layer(64'hA5A5A5A5A5A5A5A5, 64'hFFFF0000FFFF0000, 16'h0001, 0, 0);
  endtask

  task automatic test_ignore_start;
    layer(64'h0123456789ABCDEF, 64'h0, 16'hBEEF, 5, 0);
  endtask

  task automatic test_abort;
    layer(64'h0123456789ABCDEF, 64'h0, 16'h0, 0, 8);
    layer(64'h0123456789ABCDEF, 64'h0, 16'h0, 0, 0);
  endtask

  task automatic test_back_to_back;
    state0_i = 64'h0123456789ABCDEF; state1_i = 64'h00000000FFFFFFFF; seed_i = 16'h0; start_i = 1;
    @(posedge clk); #1;
    for (int j = 1; j <= 45; j++) begin
      checks += 2;
      if (a_done !== (j == 18 || j == 37)) $display("FAIL b2b_done_a j=%0d got %b", j, a_done); else passed++;
      if (b_done !== (j == 21 || j == 43)) $display("FAIL b2b_done_b j=%0d got %b", j, b_done); else passed++;
      if (j == 38) start_i = 0;
      @(posedge clk); #1;
    end
    checks += 2;
    if (a_s0 !== 64'hFEDCBA9876543210) $display("FAIL b2b_res_a got %h exp %h", a_s0, 64'hFEDCBA9876543210); else passed++;
    if (b_s1 !== 64'h00000000FFFFFFFF) $display("FAIL b2b_res_b got %h exp %h", b_s1, 64'h00000000FFFFFFFF); else passed++;
  endtask

  task automatic test_random;
    for (int n = 0; n < 4; n++)
      layer({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 0, 0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_vector_lat4;
    test_ignore_start;
    test_abort;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/shared_sbox_layer_ctrl.md
SHARED_SBOX_LAYER_CTRL -- requirements
Module: shared_sbox_layer_ctrl

Interface
REQ-001 The block SHALL have parameter LATENCY, default 1, meaning clock cycles from a nibble on sb_in*_o to its result on sb_out*_i (one per cascaded decomposed S-box stage); legal range 1..8.
REQ-002 The block SHALL have parameter NIB, default 16, meaning nibbles per layer (state width = 4*NIB).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  request to process one layer; sampled only in IDLE.
REQ-006 state0_i, state1_i  input  4*NIB each  share 0 / share 1 of layer input.
REQ-007 seed_i  input  16  guard-LFSR seed, captured with start.
REQ-008 sb_in0_o, sb_in1_o  output  4 each  nibble shares {d,c,b,a} to the external S-box stage.
REQ-009 sb_guards_o  output  2  fresh guards {rb,ra} to the external S-box stage.
REQ-010 sb_out0_i, sb_out1_i  input  4 each  nibble shares {h,g,f,e} from the external S-box pipeline.
REQ-011 busy_o  output  1  layer in progress.
REQ-012 done_o  output  1  one-cycle pulse, result valid.
REQ-013 state0_o, state1_o  output  4*NIB each  result shares; held until next done_o.

Function
REQ-014 The FSM SHALL have states IDLE, FEED, DRAIN, DONE; IDLE->FEED on start_i=1; FEED->DRAIN after NIB feed cycles; DRAIN->DONE after LATENCY further cycles; DONE->IDLE unconditionally.
REQ-015 On start accept at edge T the block SHALL latch state0_i/state1_i into internal input registers and load the LFSR with seed_i, or 16'hACE1 if seed_i==0.
REQ-016 In FEED cycle k (k=0..NIB-1, cycle T+1+k) sb_in0_o/sb_in1_o SHALL carry bits [4k+3:4k] of the latched share 0/1 (nibble 0 = LSBs first).
REQ-017 The LFSR SHALL be Fibonacci, taps x^16+x^14+x^13+x^11+1, stepping once per FEED cycle; sb_guards_o = lfsr[1:0] during FEED, each nibble receiving a distinct LFSR state.
REQ-018 Outside FEED, sb_in0_o, sb_in1_o and sb_guards_o SHALL be all-zero.
REQ-019 The block SHALL capture sb_out0_i/sb_out1_i at the edge ending cycle T+1+k+LATENCY into nibble k of internal result registers, using a capture counter independent of the feed counter (capture overlaps feed when LATENCY<NIB).
REQ-020 busy_o SHALL be 1 in cycles T+1 through T+NIB+LATENCY inclusive and 0 otherwise.
REQ-021 done_o SHALL be 1 only in cycle T+NIB+LATENCY+1 (DONE state); state0_o/state1_o SHALL update from the result registers at the edge entering DONE.
REQ-022 start_i while busy_o=1 or in DONE SHALL be ignored, with no effect on counters, LFSR or latched inputs.
REQ-023 start_i held high continuously SHALL start a new layer from the IDLE cycle following DONE (back-to-back period NIB+LATENCY+2 cycles).
REQ-024 Shares SHALL never be recombined inside the block: no logic cone may take bits of both share 0 and share 1 as inputs.

Reset
REQ-025 With rst=1 at an edge, the next state SHALL be IDLE; busy_o=0, done_o=0, state0_o=state1_o=0, sb_* outputs=0, counters=0, LFSR=16'hACE1, internal state/result registers=0.
REQ-026 rst SHALL take priority over start_i and over any in-flight layer; an aborted layer SHALL produce no done_o and leave state*_o at zero.

Verification (behavioural stub pipeline: out0=in0^4'hF, out1=in1, delay LATENCY)
REQ-027 LATENCY=1, state0_i=64'h0123456789ABCDEF, state1_i=0, start pulse at T -> done_o at T+18 only, state0_o=64'hFEDCBA9876543210, state1_o=0, busy_o high T+1..T+17.
REQ-028 LATENCY=4, state0_i=64'hA5A5A5A5A5A5A5A5, state1_i=64'hFFFF0000FFFF0000 -> done_o at T+21, state0_o=64'h5A5A5A5A5A5A5A5A, state1_o=64'hFFFF0000FFFF0000.
REQ-029 seed_i=0 -> first sb_guards_o equals 2'b01 (ACE1[1:0]); seed_i=16'h0001 -> guards sequence matches the golden LFSR model for all 16 FEED cycles.
REQ-030 start_i pulsed at T+5 during a layer -> ignored; single done_o, result unchanged versus REQ-027.
REQ-031 rst asserted at T+8 mid-layer -> next cycle busy_o=0, all outputs 0, no done_o; fresh start afterwards completes per REQ-027.
REQ-032 LATENCY=1 with real decomposed S-box stage instance, random shares/seeds -> XOR of result shares equals unmasked golden model for 10^4 layers.
